record_core: RTL
================

RECORD_CORE -- requirements
Module: record_core

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, packed-word buffer depth (power of 2, >=2).
REQ-002 i_clk  in  1  single clock; all logic rising-edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 record_start  in  1  one-cycle pulse, begins capture.
REQ-005 record_stop  in  1  one-cycle pulse, ends capture.
REQ-006 record_select  in  23x2  [0] first word address, [1] last allowed word address (inclusive).
REQ-007 record_done  out  1  one-cycle pulse when capture fully committed to SDRAM.
REQ-008 record_length  out  23  words written in last/current capture.
REQ-009 record_overflow  out  1  sticky, word dropped because FIFO full.
REQ-010 adc_valid  in  1  one-cycle strobe, adc_sample valid.
REQ-011 adc_sample  in  16  signed PCM sample.
REQ-012 record_write  out  1  SDRAM write request.
REQ-013 record_addr  out  23  SDRAM word address.
REQ-014 record_writedata  out  32  packed sample pair.
REQ-015 record_sdram_finished  in  1  one-cycle pulse, write committed.

Function
REQ-016 States: IDLE, CAPTURE, DRAIN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 IDLE + record_start: latch record_select[0..1], clear record_length, overflow, packer, FIFO; -> CAPTURE next cycle.
REQ-018 record_start outside IDLE ignored; record_stop in IDLE ignored.
REQ-019 CAPTURE: adc_valid samples packed; first sample of pair -> [31:16], second -> [15:0]; full pair pushed to FIFO same cycle second sample arrives.
REQ-020 Push when FIFO full: word dropped, record_overflow set, stays set until next accepted record_start.
REQ-021 record_stop in CAPTURE: adc_valid in the same cycle is accepted first; odd pending sample pushed with [15:0]=0; -> DRAIN.
REQ-022 Limit: when pushed-word count reaches last-first+1, capture ends as on record_stop (no padding needed); further adc_valid ignored.
REQ-023 Write side: FIFO non-empty and no write outstanding -> record_write=1, addr/data from FIFO head, held stable until record_sdram_finished.
REQ-024 Cycle of record_sdram_finished: pop FIFO, record_addr+1, record_length+1; record_write low for >=1 cycle before next request.
REQ-025 record_sdram_finished while record_write=0 ignored.
REQ-026 DRAIN: continue writes; FIFO empty and no write outstanding -> DONE, record_done=1.
REQ-027 record_length arithmetic 23-bit unsigned; addresses never wrap past record_select[1].
REQ-028 Simultaneous FIFO push and pop legal in same cycle, including full and empty edges.
REQ-029 first>last (invalid range): no writes, DONE after 1 cycle, record_length=0.

Reset
REQ-030 i_rst asserted: state IDLE, record_write=0, record_done=0, record_addr=0, record_writedata=0, record_length=0, record_overflow=0, FIFO empty, packer cleared -- immediately, mid-write included.
REQ-031 Outstanding SDRAM write at reset abandoned; late record_sdram_finished after reset ignored.

Structure
REQ-032 Shared audio package holds: ADDR_W=23, SAMPLE_W=16, WORD_W=32, record state enum.
REQ-033 One sub-module: record_fifo (synchronous FIFO, WORD_W wide, FIFO_DEPTH deep, full/empty flags).
REQ-034 Outputs registered; no combinational path adc_valid -> record_write.

Verification
REQ-035 select={0x000100,0x0001FF}, start, 4 samples 0x1111,0x2222,0x3333,0x4444, stop, immediate finished -> writes 0x11112222@0x100, 0x33334444@0x101, done, length=2.
REQ-036 3 samples 0xAAAA,0xBBBB,0xCCCC then stop -> second word 0xCCCC0000@0x101, length=2.
REQ-037 select={0x10,0x11}, 10 samples -> exactly 2 writes (0x10, 0x11), remaining samples ignored, done, length=2.
REQ-038 FIFO_DEPTH=4, finished withheld, 12 samples -> 4 words buffered, 2 dropped, overflow=1; release finished -> 4 writes, length=4.
REQ-039 i_rst asserted while record_write=1 -> record_write=0 same cycle; later finished pulse -> no state change; new start works normally.
REQ-040 stop coincident with adc_valid of 2nd sample 0x5555 after 0x7777 -> single word 0x77775555, length=1.

Source files
------------

// File: rtl/record_core_pkg.sv
// rtl/record_core_pkg.sv - shared widths, record state enum and word packing helper
package record_core_pkg;

  localparam int ADDR_W   = 23;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } record_state_e;

  // First sample of a pair lands in the upper half of the SDRAM word
  function automatic logic [WORD_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] hi,
                                                  input logic [SAMPLE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/record_core_if.sv
// rtl/record_core_if.sv - SDRAM word-write request/commit bus
interface record_core_if;
  import record_core_pkg::*;

  logic              record_write;
  logic [ADDR_W-1:0] record_addr;
  logic [WORD_W-1:0] record_writedata;
  logic              record_sdram_finished;

  modport master (
    output record_write,
    output record_addr,
    output record_writedata,
    input  record_sdram_finished
  );

  modport slave (
    input  record_write,
    input  record_addr,
    input  record_writedata,
    output record_sdram_finished
  );

endinterface

// File: rtl/record_core_fifo.sv
// rtl/record_core_fifo.sv - synchronous packed-word FIFO with full/empty flags
module record_fifo
  import record_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // Storage array; stale contents are never visible because count_q gates reads
  always_ff @(posedge i_clk) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy tracking, cleared by reset or by a new capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/record_core.sv
// rtl/record_core.sv - ADC sample capture into SDRAM via pair packer and word FIFO
module record_core
  import record_core_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   record_start,
  input  logic                   record_stop,
  input  logic [1:0][ADDR_W-1:0] record_select,
  output logic                   record_done,
  output logic [ADDR_W-1:0]      record_length,
  output logic                   record_overflow,
  input  logic                   adc_valid,
  input  logic [SAMPLE_W-1:0]    adc_sample,
  record_core_if.master          sdram
);

  localparam int CNT_W = ADDR_W + 1;

  record_state_e     state_q, state_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  pushed_q, pushed_d;
  logic [SAMPLE_W-1:0] half_q, half_d;
  logic              have_half_q, have_half_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              done_q, done_d;

  logic              fifo_clr;
  logic              fifo_push;
  logic              fifo_push_ok;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_word;
  logic [WORD_W-1:0] fifo_head;
  logic              commit;

  // Finished only counts while a request is actually outstanding
  assign commit       = write_q && sdram.record_sdram_finished;
  assign fifo_pop     = commit;
  assign fifo_push_ok = fifo_push && (!fifo_full || fifo_pop);

  record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr_i  (fifo_clr),
    .push_i (fifo_push),
    .data_i (fifo_word),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Pair samples into words; stop flushes an odd sample with a zero low half
  always_comb begin
    fifo_push   = 1'b0;
    fifo_word   = '0;
    half_d      = half_q;
    have_half_d = have_half_q;
    if (state_q == ST_CAPTURE) begin
      if (adc_valid) begin
        if (have_half_q) begin
          fifo_push   = 1'b1;
          fifo_word   = pack_pair(half_q, adc_sample);
          have_half_d = 1'b0;
        end else begin
          half_d      = adc_sample;
          have_half_d = 1'b1;
        end
      end
      if (record_stop) begin
        if (have_half_q && !adc_valid) begin
          fifo_push = 1'b1;
          fifo_word = pack_pair(half_q, {SAMPLE_W{1'b0}});
        end else if (!have_half_q && adc_valid) begin
          fifo_push = 1'b1;
          fifo_word = pack_pair(adc_sample, {SAMPLE_W{1'b0}});
        end
        have_half_d = 1'b0;
      end
    end else if (state_q == ST_IDLE && record_start) begin
      half_d      = '0;
      have_half_d = 1'b0;
    end
  end

  // Capture FSM and SDRAM write side
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    pushed_d   = pushed_q;
    overflow_d = overflow_q;
    length_d   = length_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    done_d     = 1'b0;
    fifo_clr   = 1'b0;

    // The head word stays in the FIFO until committed; the request drops
    // for at least one cycle between words
    if (commit) begin
      write_d  = 1'b0;
      addr_d   = addr_q + 1'b1;
      length_d = length_q + 1'b1;
    end else if (!write_q && !fifo_empty) begin
      write_d = 1'b1;
      wdata_d = fifo_head;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (record_start) begin
          fifo_clr   = 1'b1;
          addr_d     = record_select[0];
          length_d   = '0;
          overflow_d = 1'b0;
          pushed_d   = '0;
          limit_d    = {1'b0, record_select[1]} - {1'b0, record_select[0]} + CNT_W'(1);
          if (record_select[0] > record_select[1]) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (fifo_push && !fifo_push_ok) overflow_d = 1'b1;
        if (fifo_push_ok) pushed_d = pushed_q + 1'b1;
        if (record_stop || (fifo_push_ok && pushed_d == limit_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !write_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      limit_q     <= '0;
      pushed_q    <= '0;
      half_q      <= '0;
      have_half_q <= 1'b0;
      overflow_q  <= 1'b0;
      length_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      pushed_q    <= pushed_d;
      half_q      <= half_d;
      have_half_q <= have_half_d;
      overflow_q  <= overflow_d;
      length_q    <= length_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      done_q      <= done_d;
    end
  end

  assign record_done            = done_q;
  assign record_length          = length_q;
  assign record_overflow        = overflow_q;
  assign sdram.record_write     = write_q;
  assign sdram.record_addr      = addr_q;
  assign sdram.record_writedata = wdata_q;

endmodule
